// File: rtl/rate_limit_scheduler.sv
// Round-robin rate limiter: one shared step datapath moves one channel toward its target per clock.
// Ports:
//   clk, reset (sync, active-high)
//   req_valid/req_ready, req_ch, req_target, req_step: target and step writes
//   out_valid, out_ch, out_data: the channel updated on the last edge
//   settled_mask: one bit per channel, set when current == target
// Optional macro RLS_CH0_PRIORITY_EN gives channel 0 strict priority over the round-robin.
module rate_limit_scheduler #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 6,
  parameter int STEP_W = 3,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CH_W-1:0]   req_ch,
  input  logic [DATA_W-1:0] req_target,
  input  logic [STEP_W-1:0] req_step,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0] settled_mask
);

  logic [DATA_W-1:0] tgt_q  [NUM_CH];
  logic [DATA_W-1:0] tgt_d  [NUM_CH];
  logic [STEP_W-1:0] step_q [NUM_CH];
  logic [STEP_W-1:0] step_d [NUM_CH];
  logic [DATA_W-1:0] cur_q  [NUM_CH];
  logic [DATA_W-1:0] cur_d  [NUM_CH];

  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [NUM_CH-1:0] settled_q, settled_d;

  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] rr_elig;
  logic              gnt_vld;
  logic              pri_hit;
  logic [CH_W-1:0]   gnt;
  logic [CH_W-1:0]   idx;

  logic [DATA_W:0]   cur_x, tgt_x, stp_x;
  logic [DATA_W:0]   sum_x, dif_x, nxt_x;
  logic [DATA_W-1:0] nxt;

  assign req_ready = !reset;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i] = (cur_q[i] != tgt_q[i]) && (step_q[i] != '0);
    end
    rr_elig = elig;
`ifdef RLS_CH0_PRIORITY_EN
    // ch0 is served by the priority path, never by the rotation
    rr_elig[0] = 1'b0;
`endif
    gnt_vld = 1'b0;
    pri_hit = 1'b0;
    gnt     = '0;
    idx     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = rr_ptr_q + CH_W'(k);
      if (!gnt_vld && rr_elig[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
`ifdef RLS_CH0_PRIORITY_EN
    if (elig[0]) begin
      gnt_vld = 1'b1;
      pri_hit = 1'b1;
      gnt     = '0;
    end
`endif
  end

  // One extra bit holds the carry/borrow so clamping never wraps.
  always_comb begin
    cur_x = {1'b0, cur_q[gnt]};
    tgt_x = {1'b0, tgt_q[gnt]};
    stp_x = {{(DATA_W + 1 - STEP_W){1'b0}}, step_q[gnt]};
    sum_x = cur_x + stp_x;
    dif_x = cur_x - stp_x;
    if (cur_x < tgt_x) begin
      nxt_x = (sum_x > tgt_x) ? tgt_x : sum_x;
    end else begin
      nxt_x = (dif_x[DATA_W] || (dif_x < tgt_x)) ? tgt_x : dif_x;
    end
    nxt = nxt_x[DATA_W-1:0];
  end

  always_comb begin
    tgt_d       = tgt_q;
    step_d      = step_q;
    cur_d       = cur_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = gnt_vld;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    settled_d   = '0;
    if (gnt_vld) begin
      cur_d[gnt] = nxt;
      out_ch_d   = gnt;
      out_data_d = nxt;
      if (!pri_hit) begin
        rr_ptr_d = gnt + CH_W'(1);
      end
    end
    // The grant above already used the pre-edge target/step.
    if (req_valid && req_ready) begin
      tgt_d[req_ch]  = req_target;
      step_d[req_ch] = req_step;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      settled_d[i] = (cur_d[i] == tgt_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        tgt_q[i]  <= '0;
        step_q[i] <= '0;
        cur_q[i]  <= '0;
      end
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      settled_q   <= '1;
    end else begin
      tgt_q       <= tgt_d;
      step_q      <= step_d;
      cur_q       <= cur_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      settled_q   <= settled_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_ch       = out_ch_q;
  assign out_data     = out_data_q;
  assign settled_mask = settled_q;

endmodule

// File: tb/tb_rate_limit_scheduler.sv
// Bench for rate_limit_scheduler: directed plan scenarios plus random traffic,
// all checked against a per-channel arithmetic model.
module tb_rate_limit_scheduler;

  localparam int N  = 4;
  localparam int DW = 6;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_ch;
  logic [DW-1:0] req_target;
  logic [SW-1:0] req_step;
  logic          out_valid;
  logic [1:0]    out_ch;
  logic [DW-1:0] out_data;
  logic [N-1:0]  settled_mask;

  rate_limit_scheduler #(.NUM_CH(N), .DATA_W(DW), .STEP_W(SW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ch(req_ch), .req_target(req_target), .req_step(req_step),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data),
    .settled_mask(settled_mask)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int m_cur [N];
  int m_tgt [N];
  int m_stp [N];
  int m_rr, m_ov, m_och, m_od;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit m_elig(input int c);
    return (m_cur[c] != m_tgt[c]) && (m_stp[c] != 0);
  endfunction

  task automatic model_edge(input bit rst, input bit v, input int ch,
                            input int tg, input int st);
    int g;
    bit pri;
    int c;
    int n;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_cur[i] = 0; m_tgt[i] = 0; m_stp[i] = 0;
      end
      m_rr = 0; m_ov = 0; m_och = 0; m_od = 0;
      return;
    end
    g = -1;
    pri = 0;
`ifdef RLS_CH0_PRIORITY_EN
    if (m_elig(0)) begin
      g = 0;
      pri = 1;
    end
`endif
    for (int k = 0; k < N; k++) begin
      c = (m_rr + k) % N;
`ifdef RLS_CH0_PRIORITY_EN
      if (c == 0) continue;
`endif
      if (g < 0 && m_elig(c)) g = c;
    end
    if (g >= 0) begin
      if (m_cur[g] < m_tgt[g]) begin
        n = m_cur[g] + m_stp[g];
        if (n > m_tgt[g]) n = m_tgt[g];
      end else begin
        n = m_cur[g] - m_stp[g];
        if (n < m_tgt[g]) n = m_tgt[g];
      end
      m_cur[g] = n;
      m_ov = 1; m_och = g; m_od = n;
      if (!pri) m_rr = (g + 1) % N;
    end else begin
      m_ov = 0;
    end
    if (v) begin
      m_tgt[ch] = tg;
      m_stp[ch] = st;
    end
  endtask

  task automatic cyc(input bit rst, input bit v, input int ch,
                     input int tg, input int st);
    int sm;
    reset      = rst;
    req_valid  = v;
    req_ch     = 2'(ch);
    req_target = DW'(tg);
    req_step   = SW'(st);
    #1;
    chk("req_ready", int'(req_ready), rst ? 0 : 1);
    @(posedge clk);
    model_edge(rst, v, ch, tg, st);
    #1;
    sm = 0;
    for (int i = 0; i < N; i++) if (m_cur[i] == m_tgt[i]) sm |= (1 << i);
    chk("out_valid", int'(out_valid), m_ov);
    chk("out_ch", int'(out_ch), m_och);
    chk("out_data", int'(out_data), m_od);
    chk("settled_mask", int'(settled_mask), sm);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 2, 33, 5);
  endtask

  initial begin
    int up [7] = '{3, 6, 9, 12, 15, 18, 20};
    int dn [3] = '{13, 6, 2};
`ifdef RLS_CH0_PRIORITY_EN
    int rrc [4] = '{0, 0, 0, 2};
    int rrd [4] = '{4, 8, 10, 5};
`else
    int rrc [4] = '{0, 2, 0, 0};
    int rrd [4] = '{4, 5, 8, 10};
`endif
    int fz [3] = '{7, 5, 4};

    reset = 1; req_valid = 0; req_ch = 0; req_target = 0; req_step = 0;
    do_reset();
    chk("rst_settled", int'(settled_mask), 15);
    chk("rst_valid", int'(out_valid), 0);

    // ramp up
    cyc(0, 1, 1, 20, 3);
    for (int i = 0; i < 7; i++) begin
      idle();
      chk("up_data", int'(out_data), up[i]);
      chk("up_ch", int'(out_ch), 1);
    end
    idle();
    chk("up_done_valid", int'(out_valid), 0);
    chk("up_done_settled", int'(settled_mask), 15);

    // ramp down with clamp
    do_reset();
    cyc(0, 1, 3, 20, 7);
    repeat (3) idle();
    chk("dn_pre", int'(out_data), 20);
    cyc(0, 1, 3, 2, 7);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("dn_data", int'(out_data), dn[i]);
    end
    idle();
    chk("dn_done", int'(out_valid), 0);

    // round-robin sharing
    do_reset();
    cyc(0, 1, 0, 10, 4);
    cyc(0, 1, 2, 5, 5);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) idle();
      chk("rr_ch", int'(out_ch), rrc[i]);
      chk("rr_data", int'(out_data), rrd[i]);
    end

    // freeze and retarget
    do_reset();
    cyc(0, 1, 1, 20, 3);
    repeat (2) idle();
    cyc(0, 1, 1, 20, 0);
    chk("fz_at9", int'(out_data), 9);
    repeat (3) begin
      idle();
      chk("fz_hold", int'(out_valid), 0);
    end
    cyc(0, 1, 1, 4, 2);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("fz_data", int'(out_data), fz[i]);
    end

    // same-channel collision
    do_reset();
    cyc(0, 1, 1, 20, 3);
    repeat (2) idle();
    cyc(0, 1, 1, 7, 3);
    chk("col_old", int'(out_data), 9);
    idle();
    chk("col_new", int'(out_data), 7);
    idle();
    chk("col_settled", int'(settled_mask), 15);

    // reset mid-ramp
    do_reset();
    cyc(0, 1, 0, 10, 4);
    repeat (2) idle();
    chk("mid_at8", int'(out_data), 8);
    cyc(1, 0, 0, 0, 0);
    chk("mid_valid", int'(out_valid), 0);
    chk("mid_data", int'(out_data), 0);
    chk("mid_settled", int'(settled_mask), 15);

    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        cyc(1, $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 63), $urandom_range(0, 7));
      end else if ($urandom_range(0, 2) == 0) begin
        cyc(0, 1, $urandom_range(0, 3), $urandom_range(0, 63),
            ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 7));
      end else begin
        idle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
